// File: rtl/div_seq_if.sv
// rtl/div_seq_if.sv - execute-stage handshake bundle for the sequential divider
// master = execute stage, slave = divider.
interface div_seq_if #(
   parameter int WIDTH = 32
);
   logic                 start_i;
   logic                 annul_i;
   logic                 signed_div_i;
   logic [WIDTH-1:0]     opdata1_i;
   logic [WIDTH-1:0]     opdata2_i;
   logic [2*WIDTH-1:0]   result_o;
   logic                 ready_o;
   logic                 stallreq_o;

   modport master (
      output start_i, annul_i, signed_div_i, opdata1_i, opdata2_i,
      input  result_o, ready_o, stallreq_o
   );

   modport slave (
      input  start_i, annul_i, signed_div_i, opdata1_i, opdata2_i,
      output result_o, ready_o, stallreq_o
   );
endinterface

// File: rtl/div_seq.sv
// rtl/div_seq.sv - radix-2 restoring DIV/DIVU sequencer, one quotient bit per cycle
// Optional signed support is built only when DIV_SIGNED_EN is defined.
module div_seq #(
   parameter int WIDTH = 32
) (
   input  logic       clk,
   input  logic       rst,
   div_seq_if.slave   bus
);
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;

   state_t               state, state_nxt;
   logic [CW-1:0]        cnt;
   logic [WIDTH-1:0]     dq;        // dividend shifts out the top, quotient shifts in the bottom
   logic [WIDTH-1:0]     divisor;
   logic [WIDTH-1:0]     rem;
   logic [WIDTH:0]       shifted;
   logic [WIDTH:0]       diff;
   logic [WIDTH-1:0]     op1_abs, op2_abs;
   logic [WIDTH-1:0]     quot_fix, rem_fix;
   logic [2*WIDTH-1:0]   result;
   logic                 ready;
   logic                 accept;
   logic                 done;

   assign accept  = (state == FREE) && bus.start_i && !bus.annul_i;
   assign done    = (cnt == CW'(WIDTH));
   assign shifted = {rem, dq[WIDTH-1]};
   assign diff    = shifted - {1'b0, divisor};

`ifdef DIV_SIGNED_EN
   logic sign1, sign2;
   logic neg1, neg2;

   assign neg1     = bus.signed_div_i & bus.opdata1_i[WIDTH-1];
   assign neg2     = bus.signed_div_i & bus.opdata2_i[WIDTH-1];
   assign op1_abs  = neg1 ? -bus.opdata1_i : bus.opdata1_i;
   assign op2_abs  = neg2 ? -bus.opdata2_i : bus.opdata2_i;
   assign quot_fix = (sign1 ^ sign2) ? -dq : dq;
   assign rem_fix  = sign1 ? -rem : rem;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sign1 <= 1'b0;
         sign2 <= 1'b0;
      end else if (accept) begin
         sign1 <= neg1;
         sign2 <= neg2;
      end
   end
`else
   logic unused_signed;

   assign unused_signed = bus.signed_div_i;
   assign op1_abs  = bus.opdata1_i;
   assign op2_abs  = bus.opdata2_i;
   assign quot_fix = dq;
   assign rem_fix  = rem;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= FREE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         FREE: begin
            if (accept) state_nxt = (bus.opdata2_i == '0) ? BYZERO : ON;
         end
         BYZERO: state_nxt = END;
         ON: begin
            if (bus.annul_i) state_nxt = FREE;
            else if (done)   state_nxt = END;
         end
         END: begin
            if (!bus.start_i) state_nxt = FREE;
         end
         default: state_nxt = FREE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt     <= '0;
         dq      <= '0;
         divisor <= '0;
         rem     <= '0;
         result  <= '0;
         ready   <= 1'b0;
      end else begin
         case (state)
            FREE: begin
               if (accept && bus.opdata2_i != '0) begin
                  dq      <= op1_abs;
                  divisor <= op2_abs;
                  rem     <= '0;
                  cnt     <= '0;
               end
            end
            BYZERO: begin
               result <= '0;
               ready  <= 1'b1;
            end
            ON: begin
               if (bus.annul_i) begin
                  cnt   <= '0;
                  ready <= 1'b0;
               end else if (done) begin
                  result <= {rem_fix, quot_fix};
                  ready  <= 1'b1;
               end else begin
                  // diff MSB set means the trial subtract went negative: restore
                  rem <= diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
                  dq  <= {dq[WIDTH-2:0], ~diff[WIDTH]};
                  cnt <= cnt + CW'(1);
               end
            end
            END: begin
               if (!bus.start_i) begin
                  ready  <= 1'b0;
                  result <= '0;
               end
            end
            default: ready <= 1'b0;
         endcase
      end
   end

   assign bus.result_o   = result;
   assign bus.ready_o    = ready;
   assign bus.stallreq_o = bus.start_i & ~ready;
endmodule

// File: tb/tb_div_seq.sv
// tb/tb_div_seq.sv - directed vector bench for div_seq
// Signed vectors are included only when DIV_SIGNED_EN is defined.
module tb_div_seq;
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   div_seq_if #(.WIDTH(32)) bus();
   div_seq #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));

   int total = 0;
   int bad   = 0;

   typedef struct {
      string       name;
      logic        sgn;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] q;
      logic [31:0] r;
      int          lat;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input string name, input logic sgn,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] q, input logic [31:0] r,
                               input int lat);
      vec_t v;
      v.name = name; v.sgn = sgn; v.a = a; v.b = b; v.q = q; v.r = r; v.lat = lat;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   // Raises start, scrambles operands after the accepting edge, returns the edge index of ready
   task automatic launch(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         output int edge_idx, output logic stall_ok);
      @(negedge clk);
      bus.signed_div_i = sgn;
      bus.opdata1_i    = a;
      bus.opdata2_i    = b;
      bus.start_i      = 1'b1;
      #1 stall_ok = bus.stallreq_o;
      edge_idx = -1;
      for (int n = 0; n < 100; n++) begin
         @(posedge clk);
         #1;
         bus.opdata1_i    = $urandom;
         bus.opdata2_i    = $urandom;
         bus.signed_div_i = ~sgn;
         @(negedge clk);
         if (bus.ready_o) begin
            edge_idx = n;
            stall_ok = stall_ok & ~bus.stallreq_o;
            break;
         end
         stall_ok = stall_ok & bus.stallreq_o;
      end
   endtask

   task automatic run(input vec_t v, input int hold);
      int          e;
      logic        s_ok;
      logic        h_ok;
      logic [63:0] res;
      launch(v.sgn, v.a, v.b, e, s_ok);
      chk({v.name, " latency"}, 64'(e), 64'(v.lat));
      chk({v.name, " result"}, bus.result_o, {v.r, v.q});
      chk({v.name, " stallreq"}, 64'(s_ok), 64'd1);
      res  = bus.result_o;
      h_ok = 1'b1;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         h_ok = h_ok & bus.ready_o & (bus.result_o == res);
      end
      if (hold > 0) chk({v.name, " hold stable"}, 64'(h_ok), 64'd1);
      bus.start_i = 1'b0;
      @(negedge clk);
      chk({v.name, " drop ready"}, 64'(bus.ready_o), 64'd0);
      chk({v.name, " drop result"}, bus.result_o, 64'd0);
   endtask

   initial begin
      int   e;
      logic s_ok;

      bus.start_i = 1'b0; bus.annul_i = 1'b0; bus.signed_div_i = 1'b0;
      bus.opdata1_i = '0; bus.opdata2_i = '0;
      repeat (3) @(negedge clk);
      chk("reset ready", 64'(bus.ready_o), 64'd0);
      chk("reset result", bus.result_o, 64'd0);
      chk("reset stallreq", 64'(bus.stallreq_o), 64'd0);
      rst = 1'b1;

      vecs.push_back(mk("u100_7",    1'b0, 32'd100,        32'd7,          32'd14,         32'd2,        33));
      vecs.push_back(mk("uffff_3",   1'b0, 32'hFFFF_FFFF,  32'd3,          32'h5555_5555,  32'd0,        33));
      vecs.push_back(mk("zero_div",  1'b0, 32'h1234_5678,  32'd0,          32'd0,          32'd0,        1));
      vecs.push_back(mk("u1_max",    1'b0, 32'd1,          32'hFFFF_FFFF,  32'd0,          32'd1,        33));
      vecs.push_back(mk("umax_1",    1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,        33));
      vecs.push_back(mk("udead_16",  1'b0, 32'hDEAD_BEEF,  32'h10,         32'h0DEA_DBEE,  32'hF,        33));
      vecs.push_back(mk("u7_8",      1'b0, 32'd7,          32'd8,          32'd0,          32'd7,        33));
      vecs.push_back(mk("uneg7_2",   1'b0, 32'hFFFF_FFF9,  32'd2,          32'h7FFF_FFFC,  32'd1,        33));
`ifdef DIV_SIGNED_EN
      vecs.push_back(mk("s_m7_2",    1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF, 33));
      vecs.push_back(mk("s_ovf",     1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,        33));
      vecs.push_back(mk("s_7_m2",    1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,        33));
      vecs.push_back(mk("s_m8_m3",   1'b1, 32'hFFFF_FFF8,  32'hFFFF_FFFD,  32'd2,          32'hFFFF_FFFE, 33));
      vecs.push_back(mk("s_zero",    1'b1, 32'hFFFF_FFF9,  32'd0,          32'd0,          32'd0,        1));
`else
      vecs.push_back(mk("sgn_ignored", 1'b1, 32'hFFFF_FFF9, 32'd2,         32'h7FFF_FFFC,  32'd1,        33));
`endif

      foreach (vecs[i]) run(vecs[i], (i == 0) ? 5 : 0);

      // annul at iteration 10, then a fresh 9/3 must be accepted with full latency
      @(negedge clk);
      bus.signed_div_i = 1'b0; bus.opdata1_i = 32'hFFFF_FFFF; bus.opdata2_i = 32'd3;
      bus.start_i = 1'b1;
      repeat (11) @(posedge clk);
      @(negedge clk);
      bus.annul_i = 1'b1;
      @(negedge clk);
      chk("annul ready0", 64'(bus.ready_o), 64'd0);
      @(negedge clk);
      chk("annul ready1", 64'(bus.ready_o), 64'd0);
      bus.annul_i = 1'b0;
      bus.start_i = 1'b0;
      run(mk("after_annul_9_3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 33), 0);

      // asynchronous reset at iteration 20
      @(negedge clk);
      bus.opdata1_i = 32'hFFFF_FFFF; bus.opdata2_i = 32'd7; bus.start_i = 1'b1;
      repeat (21) @(posedge clk);
      #2 rst = 1'b0;
      #1;
      chk("rst mid ready", 64'(bus.ready_o), 64'd0);
      chk("rst mid result", bus.result_o, 64'd0);
      @(negedge clk);
      bus.start_i = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      run(mk("after_rst_50_5", 1'b0, 32'd50, 32'd5, 32'd10, 32'd0, 33), 0);

      // asynchronous reset while holding a finished result
      launch(1'b0, 32'd100, 32'd7, e, s_ok);
      chk("end pre-rst result", bus.result_o, {32'd2, 32'd14});
      #2 rst = 1'b0;
      #1;
      chk("rst end ready", 64'(bus.ready_o), 64'd0);
      chk("rst end result", bus.result_o, 64'd0);
      bus.start_i = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1);
   end
endmodule
